// File: rtl/cos_arb_pkg.sv
// Shared types and sizing helpers for the Cosinus arbiter slice.
// Holds the FSM state enum, default operand widths and clog2.
package cos_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_t;

    localparam int DEF_X_W = 10;
    localparam int DEF_Y_W = 8;
    localparam int DEF_R_W = 10;

    // Never returns less than 1 so every index has a real bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set bit of req starting at ptr.
// Ports: req, ptr in; winner index and valid out. Purely combinational.
module rr_pick
    import cos_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             valid
);

    logic [IW:0] j;

    // Walk from farthest to nearest so the bit at ptr is written last
    // and therefore wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        j      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = {1'b0, ptr} + (IW + 1)'(k);
            if (j >= (IW + 1)'(N_REQ)) begin
                j = j - (IW + 1)'(N_REQ);
            end
            if (req[j[IW-1:0]]) begin
                winner = j[IW-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cos_arbiter.sv
// Round-robin arbiter sharing one Cosinus unit among N_REQ clients.
// Ports: req/req_x/req_y from clients; done/err/result back; cos_* to unit.
module cos_arbiter
    import cos_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int R_W     = DEF_R_W,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*X_W-1:0] req_x,
    input  logic [N_REQ*Y_W-1:0] req_y,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic [R_W-1:0]     result,
    output logic               busy,
    output logic               cos_start,
    output logic [X_W-1:0]     cos_x,
    output logic [Y_W-1:0]     cos_y,
    input  logic               cos_ready,
    input  logic [R_W-1:0]     cos_result
);

    localparam int IW = clog2(N_REQ);
    localparam int TW = clog2(TIMEOUT + 1);

    state_t         state, state_n;
    logic [IW-1:0]  ptr, owner, win;
    logic [TW-1:0]  timer;
    logic           errf, pv;
    logic           latch, cap, tout;
    logic [X_W-1:0] sel_x;
    logic [Y_W-1:0] sel_y;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (win),
        .valid  (pv)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) begin
                sel_x = req_x[i*X_W +: X_W];
                sel_y = req_y[i*Y_W +: Y_W];
            end
        end
    end

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        cap     = 1'b0;
        tout    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cos_ready && pv) begin
                    latch   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: state_n = BUSY;
            BUSY: begin
                // ready is checked first so a tie never flags an error
                if (cos_ready) begin
                    cap     = 1'b1;
                    state_n = RESP;
                end else if (timer == TW'(TIMEOUT)) begin
                    tout    = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        done      = '0;
        err       = '0;
        cos_start = (state == ISSUE);
        busy      = (state != IDLE);
        if (state == RESP) begin
            done[owner] = 1'b1;
            err[owner]  = errf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            timer  <= '0;
            errf   <= 1'b0;
            result <= '0;
            cos_x  <= '0;
            cos_y  <= '0;
        end else begin
            state <= state_n;
            if (latch) begin
                owner <= win;
                cos_x <= sel_x;
                cos_y <= sel_y;
            end
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == BUSY) begin
                timer <= timer + 1'b1;
            end
            if (cap) begin
                result <= cos_result;
            end
            if (tout) begin
                result <= '0;
                errf   <= 1'b1;
            end
            if (state == RESP) begin
                errf <= 1'b0;
                if (owner == IW'(N_REQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= owner + 1'b1;
                end
            end
        end
    end

endmodule
